rr_mux_8x1: RTL and testbench

Eight-channel, round-robin, time-division multiplexer that merges eight valid/ready source streams into one registered output stream. Each output word carries the 3-bit index of its source channel, so a downstream 1x8 demultiplexer can route it back to the matching lane. This block is the gather end of the channel-select scheme whose scatter end is the 1x8 demux. Arbitration is fair: no requesting channel waits more than seven grants.

---
 rtl/rr_mux_pkg.sv | 9 +
 rtl/rr_arbiter_8.sv | 27 ++
 rtl/rr_mux_8x1.sv | 51 +++++
 tb/tb_rr_mux_8x1.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants and pointer helper for the 8-channel round-robin mux
package rr_mux_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
        return g + SEL_W'(1);
    endfunction
endpackage

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: combinational round-robin grant search starting at ptr
module rr_arbiter_8
    import rr_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);
    logic [SEL_W-1:0] off;
    logic             hit;

    // rotate the search so ptr is checked first; the lowest rotated offset wins
    always_comb begin
        off = '0;
        hit = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                off = SEL_W'(i);
                hit = 1'b1;
            end
        end
        gnt_idx = ptr + off;
        gnt = (en && hit) ? NUM_CH'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/rr_mux_8x1.sv
// rr_mux_8x1: round-robin 8-to-1 stream mux with registered output and source tag
module rr_mux_8x1
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready
);
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  g;
    logic [NUM_CH-1:0] gnt;
    logic              load;

    // the register can accept a word when empty or draining; never while in reset
    assign load = (!out_valid || out_ready) && !rst;

    rr_arbiter_8 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (load),
        .gnt     (gnt),
        .gnt_idx (g)
    );

    assign in_ready = gnt;

    // output register and pointer: load on transfer, clear valid on a bare drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (|gnt) begin
            out_valid <= 1'b1;
            out_data  <= in_data[g*WIDTH +: WIDTH];
            out_sel   <= g;
            ptr       <= next_ptr(g);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_8x1.sv
// tb_rr_mux_8x1: directed self-checking bench for the round-robin 8x1 mux
module tb_rr_mux_8x1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_valid = 8'h00;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready = 1'b0;
    int          errors = 0;
    int          checks = 0;

    rr_mux_8x1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] s, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_sel"}, 32'(out_sel), 32'(s));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk_out("rst", 1'b0, 3'd0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rr_ready", 32'(in_ready), 32'(8'h01 << (i % 8)));
            tick();
            chk_out("rr", 1'b1, 3'(i % 8), 8'hA0 + 8'(i % 8));
        end
        in_valid = 8'h10;
        #1;
        chk("park_ready", 32'(in_ready), 32'h10);
        tick();
        chk_out("park", 1'b1, 3'd4, 8'hA4);
        in_valid = 8'b0001_0010;
        #1;
        chk("sparse_wrap_ready", 32'(in_ready), 32'h02);
        tick();
        chk_out("sparse_wrap", 1'b1, 3'd1, 8'hA1);
        #1;
        chk("sparse_next_ready", 32'(in_ready), 32'h10);
        tick();
        chk_out("sparse_next", 1'b1, 3'd4, 8'hA4);
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("stall", 1'b1, 3'd4, 8'hA4);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(in_ready), 32'h20);
        tick();
        chk_out("unstall", 1'b1, 3'd5, 8'hA5);
        in_valid = 8'h08;
        #1;
        chk("single_ready", 32'(in_ready), 32'h08);
        tick();
        chk_out("single", 1'b1, 3'd3, 8'hA3);
        in_valid = 8'h00;
        #1;
        chk("drain_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("drain", 1'b0, 3'd3, 8'hA3);
        in_valid = 8'h80;
        tick();
        chk_out("pre_arst", 1'b1, 3'd7, 8'hA7);
        #2;
        rst = 1'b1;
        #1;
        chk_out("arst", 1'b0, 3'd0, 8'h00);
        chk("arst_ready", 32'(in_ready), 32'h0);
        #1;
        rst      = 1'b0;
        in_valid = 8'hFF;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'h01);
        tick();
        chk_out("post_rst0", 1'b1, 3'd0, 8'hA0);
        tick();
        chk_out("post_rst1", 1'b1, 3'd1, 8'hA1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
